// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-back path.
//   REG_NUM_W  width of a register number
//   DATA_W     width of a register value
//   ZERO_REG   hard-wired zero register; writes to it are dropped
//   wb_state_t write-back arbiter FSM states
package regfile_pkg;

  localparam int REG_NUM_W = 5;
  localparam int DATA_W    = 32;
  localparam logic [REG_NUM_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    URGENT = 2'd2
  } wb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
// Searches req_i starting at index ptr_i and wrapping modulo NREQ; the first
// set bit wins.
//   req_i    [NREQ]   request vector
//   ptr_i    [PTR_W]  index searched first
//   grant_o  [NREQ]   one-hot grant (all zero when no request)
//   idx_o    [PTR_W]  index of the granted request
//   found_o  1        some request was granted
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             found_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!found_o && req_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = PTR_W'(j);
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port among NREQ
// write-back sources with round-robin arbitration and a starvation watchdog.
//
// Handshake: requester i transfers in a cycle where Req_Valid[i] & Req_Ready[i]
// are both high at the rising edge. Req_Ready is combinational, one-hot or
// zero, only ever set on a valid requester, and zero while Stall or reset.
// A requester keeps Req_Num/Req_Data stable while valid and not granted; it
// may drop Valid before grant to withdraw.
//
// Ports:
//   Clk, Rst_n (async active-low), Stall (no grants, state/counters frozen)
//   Req_Valid/Req_Num/Req_Data in, Req_Ready out  - per-requester handshake
//   WE, W_Num, W_Data  - registered register-file write port (1 cycle latency)
//   Urgent             - high while the FSM is in URGENT
//   R1/R2 _Num/_Raw in, _Fwd out - read-port bypass of the pending write
//
// Build option: define WB_FWD_EN to enable read-port forwarding; otherwise
// R1_Fwd/R2_Fwd pass R1_Raw/R2_Raw straight through.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int MAXWAIT = 8
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Stall,
  input  logic [NREQ-1:0]           Req_Valid,
  input  logic [NREQ*REG_NUM_W-1:0] Req_Num,
  input  logic [NREQ*DATA_W-1:0]    Req_Data,
  output logic [NREQ-1:0]           Req_Ready,
  output logic                      WE,
  output logic [REG_NUM_W-1:0]      W_Num,
  output logic [DATA_W-1:0]         W_Data,
  output logic                      Urgent,
  input  logic [REG_NUM_W-1:0]      R1_Num,
  input  logic [REG_NUM_W-1:0]      R2_Num,
  input  logic [DATA_W-1:0]         R1_Raw,
  input  logic [DATA_W-1:0]         R2_Raw,
  output logic [DATA_W-1:0]         R1_Fwd,
  output logic [DATA_W-1:0]         R2_Fwd
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(MAXWAIT + 1);
  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAXWAIT);

  wb_state_t            state_q, state_d;
  logic                 urgent_q;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q [NREQ];
  logic [CNT_W-1:0]     cnt_d [NREQ];
  logic                 we_q, we_d;
  logic [REG_NUM_W-1:0] wnum_q, wnum_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;

  // Normal round-robin candidate.
  logic [NREQ-1:0]  rr_grant;
  logic [PTR_W-1:0] rr_idx;
  logic             rr_found;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
    .req_i   (Req_Valid),
    .ptr_i   (ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  // Watchdog candidate: lowest-index requester that is valid and saturated.
  // A saturated requester that just withdrew is skipped, so URGENT can fall
  // back to the round-robin pick for that one cycle.
  logic [NREQ-1:0]  u_grant;
  logic [PTR_W-1:0] u_idx;
  logic             u_found;

  always_comb begin
    u_grant = '0;
    u_idx   = '0;
    u_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cnt_q[i] == SAT && Req_Valid[i]) begin
        u_grant = '0;
        u_grant[i] = 1'b1;
        u_idx   = PTR_W'(i);
        u_found = 1'b1;
      end
    end
  end

  logic [NREQ-1:0]  gnt;
  logic [PTR_W-1:0] gidx;
  logic             gfound;

  always_comb begin
    gnt    = '0;
    gidx   = '0;
    gfound = 1'b0;
    if (Rst_n && !Stall) begin
      if (state_q == URGENT && u_found) begin
        gnt    = u_grant;
        gidx   = u_idx;
        gfound = 1'b1;
      end else begin
        gnt    = rr_grant;
        gidx   = rr_idx;
        gfound = rr_found;
      end
    end
  end

  assign Req_Ready = gnt;

  // Next-state logic. The FSM looks at the next counter values so a requester
  // that saturates is served in the very cycle its counter reads MAXWAIT.
  always_comb begin
    logic any_sat;
    any_sat = 1'b0;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    wnum_d  = wnum_q;
    wdata_d = wdata_q;
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!Stall) begin
        if (!Req_Valid[i] || gnt[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] != SAT) begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (cnt_d[i] == SAT) begin
        any_sat = 1'b1;
      end
    end
    if (gfound) begin
      ptr_d   = PTR_W'((int'(gidx) + 1) % NREQ);
      wnum_d  = Req_Num[int'(gidx)*REG_NUM_W +: REG_NUM_W];
      wdata_d = Req_Data[int'(gidx)*DATA_W +: DATA_W];
      // Register 0 is hard-wired: the handshake completes but nothing commits.
      we_d    = (wnum_d != ZERO_REG);
    end
    if (Stall) begin
      state_d = state_q;
    end else if (any_sat) begin
      state_d = URGENT;
    end else if (|Req_Valid) begin
      state_d = ACTIVE;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      urgent_q <= 1'b0;
      ptr_q    <= '0;
      we_q     <= 1'b0;
      wnum_q   <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      urgent_q <= (state_d == URGENT);
      ptr_q    <= ptr_d;
      we_q     <= we_d;
      wnum_q   <= wnum_d;
      wdata_q  <= wdata_d;
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign WE     = we_q;
  assign W_Num  = wnum_q;
  assign W_Data = wdata_q;
  assign Urgent = urgent_q;

`ifdef WB_FWD_EN
  // Bypass the write that is on the port but not yet committed.
  assign R1_Fwd = (we_q && wnum_q == R1_Num && R1_Num != ZERO_REG) ? wdata_q : R1_Raw;
  assign R2_Fwd = (we_q && wnum_q == R2_Num && R2_Num != ZERO_REG) ? wdata_q : R2_Raw;
`else
  logic fwd_unused;
  assign fwd_unused = ^{R1_Num, R2_Num};
  assign R1_Fwd = R1_Raw;
  assign R2_Fwd = R2_Raw;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int NREQ    = 3;
  localparam int MAXWAIT = 8;
`ifdef WB_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall;
  logic [2:0]  Req_Valid;
  logic [14:0] Req_Num;
  logic [95:0] Req_Data;
  logic [2:0]  Req_Ready;
  logic        WE;
  logic [4:0]  W_Num;
  logic [31:0] W_Data;
  logic        Urgent;
  logic [4:0]  R1_Num, R2_Num;
  logic [31:0] R1_Raw, R2_Raw, R1_Fwd, R2_Fwd;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .MAXWAIT(MAXWAIT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall),
    .Req_Valid(Req_Valid), .Req_Num(Req_Num), .Req_Data(Req_Data),
    .Req_Ready(Req_Ready), .WE(WE), .W_Num(W_Num), .W_Data(W_Data),
    .Urgent(Urgent),
    .R1_Num(R1_Num), .R2_Num(R2_Num), .R1_Raw(R1_Raw), .R2_Raw(R2_Raw),
    .R1_Fwd(R1_Fwd), .R2_Fwd(R2_Fwd)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  num;
    logic [31:0] data;
    logic        urg;
    logic [31:0] f1;
    logic [31:0] f2;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ready",  32'(Req_Ready), 32'(e.rdy));
      chk("we",     32'(WE),        32'(e.we));
      chk("w_num",  32'(W_Num),     32'(e.num));
      chk("w_data", W_Data,         e.data);
      chk("urgent", 32'(Urgent),    32'(e.urg));
      chk("r1_fwd", R1_Fwd,         e.f1);
      chk("r2_fwd", R2_Fwd,         e.f2);
    end
  end

  // ---------------- reference model ----------------
  // Rules: a requester that has waited MAXWAIT cycles takes priority (lowest
  // index first); otherwise the first valid one from the rotating pointer.
  int          ptr_m;
  int          wait_m [NREQ];
  logic        we_m;
  logic [4:0]  num_m;
  logic [31:0] data_m;

  logic [4:0]  pnum  [NREQ];
  logic [31:0] pdata [NREQ];
  logic [2:0]  pend;
  int          last_g;
  bit          force_ptr = 1'b0;
  bit          fix_r = 1'b0;

  function automatic void model_reset();
    ptr_m = 0;
    we_m = 1'b0; num_m = '0; data_m = '0;
    for (int i = 0; i < NREQ; i++) wait_m[i] = 0;
  endfunction

  function automatic bit any_sat();
    for (int i = 0; i < NREQ; i++) if (wait_m[i] >= MAXWAIT) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_pick(input logic [2:0] vld, input logic st);
    if (st) return -1;
    if (any_sat())
      for (int i = 0; i < NREQ; i++) if (wait_m[i] >= MAXWAIT && vld[i]) return i;
    for (int k = 0; k < NREQ; k++) if (vld[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return -1;
  endfunction

  function automatic void model_update(input logic [2:0] vld, input logic st, input int g);
    we_m = 1'b0;
    if (st) return;
    for (int i = 0; i < NREQ; i++) begin
      if (!vld[i] || i == g) wait_m[i] = 0;
      else if (wait_m[i] < MAXWAIT) wait_m[i] = wait_m[i] + 1;
    end
    if (g >= 0) begin
      ptr_m  = (g + 1) % NREQ;
      num_m  = pnum[g];
      data_m = pdata[g];
      we_m   = (pnum[g] != 5'd0);
    end
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] n, input logic [31:0] raw);
    if (FWD_EN && we_m && num_m == n && n != 5'd0) return data_m;
    return raw;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic st);
    exp_t e;
    int g;
    logic [2:0] vld;
    @(posedge Clk);
    #1;
    if (force_ptr) ptr_m = 0;
    vld = pend;
    Stall = st;
    Req_Valid = vld;
    for (int i = 0; i < NREQ; i++) begin
      Req_Num[5*i +: 5]   = pnum[i];
      Req_Data[32*i +: 32] = pdata[i];
    end
    if (fix_r) begin
      R1_Num = 5'd3; R1_Raw = 32'h0;
    end else begin
      R1_Num = ($urandom_range(0, 1) == 1) ? num_m : 5'($urandom_range(0, 31));
      R1_Raw = $urandom;
    end
    R2_Num = ($urandom_range(0, 1) == 1) ? num_m : 5'($urandom_range(0, 31));
    R2_Raw = $urandom;
    g = model_pick(vld, st);
    e.rdy  = (g >= 0) ? 3'(1 << g) : 3'b000;
    e.we   = we_m;
    e.num  = num_m;
    e.data = data_m;
    e.urg  = any_sat();
    e.f1   = fwd(R1_Num, R1_Raw);
    e.f2   = fwd(R2_Num, R2_Raw);
    exp_q.push_back(e);
    model_update(vld, st, g);
    last_g = g;
    if (g >= 0) pend[g] = 1'b0;
  endtask

  task automatic load(input int i, input logic [4:0] n, input logic [31:0] d);
    pend[i] = 1'b1; pnum[i] = n; pdata[i] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int got_cyc;
    Rst_n = 1'b0; Stall = 1'b0; Req_Valid = 3'b111;
    Req_Num = '0; Req_Data = '0;
    R1_Num = '0; R2_Num = '0; R1_Raw = '0; R2_Raw = '0;
    pend = '0; last_g = -1;
    for (int i = 0; i < NREQ; i++) begin pnum[i] = '0; pdata[i] = '0; end
    model_reset();
    #12;
    chk("ready_in_reset", 32'(Req_Ready), 32'h0);
    chk("we_in_reset", 32'(WE), 32'h0);
    Req_Valid = '0;
    @(negedge Clk);
    Rst_n = 1'b1;

    // Idle cycle after reset: all outputs at reset values.
    step(1'b0);

    // Reset asserted while a write is on the port.
    load(0, 5'd4, 32'hDEAD_BEEF);
    step(1'b0);
    @(posedge Clk);
    #1;
    chk("we_before_reset", 32'(WE), 32'h1);
    Stall = 1'b0; Req_Valid = 3'b111;
    Rst_n = 1'b0;
    #1;
    chk("we_async_reset",    32'(WE),        32'h0);
    chk("wnum_async_reset",  32'(W_Num),     32'h0);
    chk("wdata_async_reset", W_Data,         32'h0);
    chk("ready_async_reset", 32'(Req_Ready), 32'h0);
    model_reset();
    pend = '0;
    Req_Valid = '0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // All three valid: order 5,6,7 proves pointer restarted at 0.
    load(0, 5'd5, 32'hAAAA_AAAA);
    load(1, 5'd6, 32'hBBBB_BBBB);
    load(2, 5'd7, 32'hCCCC_CCCC);
    repeat (5) step(1'b0);

    // Write to register 0: handshake completes, WE stays low.
    load(0, 5'd0, 32'hFFFF_FFFF);
    repeat (3) step(1'b0);

    // Stall for 4 cycles with requester 1 pending, then release.
    load(1, 5'd9, 32'h0909_0909);
    repeat (4) step(1'b1);
    repeat (3) step(1'b0);

    // Starvation: pointer pinned to 0, requester 0 refires every cycle.
    force dut.ptr_q = '0;
    force_ptr = 1'b1;
    load(2, 5'd12, 32'h1212_3434);
    got_cyc = 0;
    for (int c = 1; c <= 14; c++) begin
      load(0, 5'($urandom_range(1, 31)), $urandom);
      step(1'b0);
      if (last_g == 2) begin
        got_cyc = c;
        break;
      end
    end
    chk("urgent_grant_by_9", 32'(got_cyc >= 1 && got_cyc <= MAXWAIT + 1), 32'h1);
    @(negedge Clk);
    release dut.ptr_q;
    force_ptr = 1'b0;
    pend = '0;
    repeat (3) step(1'b0);

    // Forwarding: write r3 then read r3 during the WE cycle.
    load(0, 5'd3, 32'h1234_5678);
    step(1'b0);
    fix_r = 1'b1;
    step(1'b0);
    fix_r = 1'b0;
    step(1'b0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic st;
      st = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 4)
          load(i, 5'($urandom_range(0, 31)), $urandom);
        else if (pend[i] && !st && $urandom_range(0, 19) == 0)
          pend[i] = 1'b0;
      end
      step(st);
    end
    pend = '0;
    repeat (2) step(1'b0);
    @(posedge Clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
